grant_dispatch: RTL and testbench
=================================

# grant_dispatch

Consumes the 32-bit one-hot `grant` vector produced by the 32-way tree arbiter and turns it into a single issued transaction toward the shared resource. It encodes the winner to an index, presents it on a valid/ready handshake, counts completion beats, and returns a one-cycle per-requester `release` pulse so the winning requester can drop its `req`. New grants are accepted only while idle, so at most one transaction is in flight at a time.

## Interface
- `N`, 32, number of requesters (width of `grant`/`release`)
- `IDX_W`, 5, index width; must equal $clog2(N)
- `CNT_W`, 8, beat-length/counter width

- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `grant`  in  N  grant vector from arbiter (expected one-hot or zero)
- `beat_len`  in  CNT_W  beats for the transaction, sampled together with `grant`
- `out_valid`  out  1  transaction offered to resource
- `out_idx`  out  IDX_W  encoded winner index
- `out_len`  out  CNT_W  captured `beat_len`
- `out_ready`  in  1  resource accepts when `out_valid && out_ready`
- `beat`  in  1  one-cycle strobe per completed beat
- `busy`  out  1  high in any state other than IDLE
- `release`  out  N  one-hot, one-cycle pulse at bit `out_idx` on completion
- `err`  out  1  sticky grant-integrity error (only with macro, else tied 0)

## Operation
- FSM states: IDLE, ISSUE, BUSY, RELEASE.
- IDLE: if `grant != 0`, capture index and `beat_len`, go to ISSUE. Multi-hot grant: the lowest set bit wins.
- ISSUE: `out_valid=1`, `out_idx`/`out_len` held stable. On `out_ready`, go to BUSY, clear the beat counter. If `out_len == 0`, go directly to RELEASE.
- BUSY: each `beat` increments the counter. When a beat brings the count to `out_len`, go to RELEASE.
- RELEASE: `release[out_idx]=1` for exactly one cycle, then go to IDLE.
- Outside IDLE, `grant` is ignored entirely. The arbiter may keep asserting the same grant until its requester sees `release`.
- `beat` outside BUSY is ignored. This includes the cycle in which the handshake completes: counting starts the cycle after acceptance.
- The counter is CNT_W bits wide and never wraps, because the exit compare precedes any overflow.
- `out_idx`/`out_len` keep their last values outside ISSUE. They are meaningful only while `out_valid`.

## Timing
- Reset values: state=IDLE, `out_valid=0`, `out_idx=0`, `out_len=0`, `busy=0`, `release=0`, `err=0`, counter=0.
- Reset asserted mid-transaction returns the block to IDLE on the next edge with no `release` pulse.
- Grant-to-`out_valid` latency is 1 cycle: grant sampled at edge k, `out_valid` high after edge k.
- Handshake at edge h, length L≥1: the L-th beat is sampled at edge b, and `release` is high in the cycle after b.
- Handshake at edge h, length 0: `release` is high in the cycle after h.
- After RELEASE, the next grant can be sampled the cycle after the pulse drops. The minimum idle gap between transactions is 1 cycle.
- `busy` is registered and is high from the ISSUE entry through the RELEASE cycle.

## Configuration
- `GRANT_DISPATCH_ONEHOT_CHECK_EN` defined: in IDLE, a multi-hot `grant` sets `err` at the next edge. `err` stays sticky until `rst`. Dispatch still proceeds with the lowest set bit.
- Not defined: no check logic is built, and `err` is constant 0.

## Test plan
- Single grant: `grant=32'h0000_0100`, `beat_len=3`, `out_ready=1`, three `beat` pulses → `out_idx=8`, `out_len=3`, `release=32'h0000_0100` for one cycle after the third beat, then `busy=0`.
- Backpressure: hold `out_ready=0` for 5 cycles with `grant=bit 31` → `out_valid` stays high with `out_idx=31` stable. Beats during stall are ignored. After acceptance and `beat_len=1` beats, `release[31]` pulses.
- Zero length: `grant=bit 0`, `beat_len=0`, ready on first offer → `release[0]` one cycle after the handshake, no beats needed.
- Grant while busy: during BUSY, drive `grant=bit 5` → ignored. Once back in IDLE with grant still high → new transaction with `out_idx=5`.
- Multi-hot: `grant=32'h0000_0014` → `out_idx=2`. `err=1` with the macro defined, `err=0` without it. `err` is cleared only by `rst`.
- Reset mid-op: assert `rst` in BUSY after 1 of 4 beats → all outputs return to reset values next cycle, no `release` pulse.

Source files
------------

// File: rtl/grant_dispatch.sv
// Turns a one-hot arbiter grant into a single valid/ready transaction, counts completion beats,
// and pulses a per-requester release. Optional grant-integrity check: GRANT_DISPATCH_ONEHOT_CHECK_EN.
module grant_dispatch #(
   parameter int unsigned N     = 32,
   parameter int unsigned IDX_W = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N-1:0]     grant_i,
   input  logic [CNT_W-1:0] beat_len_i,
   output logic             out_valid_o,
   output logic [IDX_W-1:0] out_idx_o,
   output logic [CNT_W-1:0] out_len_o,
   input  logic             out_ready_i,
   input  logic             beat_i,
   output logic             busy_o,
   output logic [N-1:0]     release_o,
   output logic             err_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      BUSY    = 2'd2,
      RELEASE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             busy_q;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_found;

   // Lowest set bit wins on a multi-hot grant.
   always_comb begin
      enc_idx   = '0;
      enc_found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_i[i] && !enc_found) begin
            enc_idx   = IDX_W'(i);
            enc_found = 1'b1;
         end
      end
   end

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (enc_found) begin
               idx_d   = enc_idx;
               len_d   = beat_len_i;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (out_ready_i) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? RELEASE : BUSY;
            end
         end
         BUSY: begin
            // Exit compare happens on the beat that reaches len, so the counter never wraps.
            if (beat_i) begin
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign out_valid_o = (state_q == ISSUE);
   assign out_idx_o   = idx_q;
   assign out_len_o   = len_q;
   assign busy_o      = busy_q;
   assign release_o   = (state_q == RELEASE) ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;

`ifdef GRANT_DISPATCH_ONEHOT_CHECK_EN
   logic err_q;
   logic multi_hot;

   assign multi_hot = ((grant_i & (grant_i - 1'b1)) != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (state_q == IDLE && multi_hot) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_grant_dispatch.sv
// Directed self-checking bench for grant_dispatch; expected values are hand-computed per vector.
module tb_grant_dispatch;

   localparam int unsigned N     = 32;
   localparam int unsigned IDX_W = 5;
   localparam int unsigned CNT_W = 8;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [N-1:0]     grant_i;
   logic [CNT_W-1:0] beat_len_i;
   logic             out_valid_o;
   logic [IDX_W-1:0] out_idx_o;
   logic [CNT_W-1:0] out_len_o;
   logic             out_ready_i;
   logic             beat_i;
   logic             busy_o;
   logic [N-1:0]     release_o;
   logic             err_o;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic        exp_err;

   grant_dispatch #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .grant_i     (grant_i),
      .beat_len_i  (beat_len_i),
      .out_valid_o (out_valid_o),
      .out_idx_o   (out_idx_o),
      .out_len_o   (out_len_o),
      .out_ready_i (out_ready_i),
      .beat_i      (beat_i),
      .busy_o      (busy_o),
      .release_o   (release_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef GRANT_DISPATCH_ONEHOT_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst_i = 1'b1; grant_i = '0; beat_len_i = '0; out_ready_i = 1'b0; beat_i = 1'b0;
      step(); step();
      check("rst_valid",   32'(out_valid_o), 32'd0);
      check("rst_idx",     32'(out_idx_o),   32'd0);
      check("rst_len",     32'(out_len_o),   32'd0);
      check("rst_busy",    32'(busy_o),      32'd0);
      check("rst_release", release_o,        32'd0);
      check("rst_err",     32'(err_o),       32'd0);
      rst_i = 1'b0;
      step();

      // Single grant, three beats.
      grant_i = 32'h0000_0100; beat_len_i = 8'd3; out_ready_i = 1'b1;
      step();
      check("t1_valid", 32'(out_valid_o), 32'd1);
      check("t1_idx",   32'(out_idx_o),   32'd8);
      check("t1_len",   32'(out_len_o),   32'd3);
      check("t1_busy",  32'(busy_o),      32'd1);
      grant_i = '0;
      step();
      check("t1_valid_drop", 32'(out_valid_o), 32'd0);
      check("t1_busy_hs",    32'(busy_o),      32'd1);
      beat_i = 1'b1;
      step(); step();
      check("t1_no_early_rel", release_o, 32'd0);
      step();
      beat_i = 1'b0;
      check("t1_release", release_o, 32'h0000_0100);
      check("t1_busy_rel", 32'(busy_o), 32'd1);
      step();
      check("t1_rel_drop", release_o, 32'd0);
      check("t1_idle",     32'(busy_o), 32'd0);

      // Backpressure with beats during the stall and on the handshake cycle.
      grant_i = 32'h8000_0000; beat_len_i = 8'd1; out_ready_i = 1'b0; beat_i = 1'b1;
      step();
      grant_i = '0;
      for (int i = 0; i < 5; i++) begin
         check("t2_stall_valid", 32'(out_valid_o), 32'd1);
         check("t2_stall_idx",   32'(out_idx_o),   32'd31);
         step();
      end
      out_ready_i = 1'b1;
      step();
      beat_i = 1'b0;
      check("t2_hs_valid", 32'(out_valid_o), 32'd0);
      check("t2_hs_norel", release_o,        32'd0);
      step();
      check("t2_wait_norel", release_o,     32'd0);
      check("t2_wait_busy",  32'(busy_o),   32'd1);
      beat_i = 1'b1;
      step();
      beat_i = 1'b0;
      check("t2_release", release_o, 32'h8000_0000);
      step();
      check("t2_idle", 32'(busy_o), 32'd0);

      // Zero length: release the cycle after the handshake.
      grant_i = 32'h0000_0001; beat_len_i = 8'd0; out_ready_i = 1'b1;
      step();
      check("t3_valid", 32'(out_valid_o), 32'd1);
      check("t3_idx",   32'(out_idx_o),   32'd0);
      check("t3_len",   32'(out_len_o),   32'd0);
      grant_i = '0;
      step();
      check("t3_release", release_o, 32'h0000_0001);
      step();
      check("t3_rel_drop", release_o,    32'd0);
      check("t3_idle",     32'(busy_o),  32'd0);

      // Grant while busy is ignored, then picked up once idle.
      grant_i = 32'h0000_1000; beat_len_i = 8'd2;
      step();
      check("t4_idx12", 32'(out_idx_o), 32'd12);
      step();
      grant_i = 32'h0000_0020; beat_i = 1'b1;
      step();
      check("t4_idx_held", 32'(out_idx_o),   32'd12);
      check("t4_novalid",  32'(out_valid_o), 32'd0);
      step();
      beat_i = 1'b0;
      check("t4_release12", release_o, 32'h0000_1000);
      step();
      check("t4_gap_idle",  32'(busy_o),      32'd0);
      check("t4_gap_valid", 32'(out_valid_o), 32'd0);
      step();
      check("t4_valid5", 32'(out_valid_o), 32'd1);
      check("t4_idx5",   32'(out_idx_o),   32'd5);
      grant_i = '0;
      step();
      beat_i = 1'b1;
      step(); step();
      beat_i = 1'b0;
      check("t4_release5", release_o, 32'h0000_0020);
      step();

      // Multi-hot grant: lowest bit wins, err is sticky when the check is built.
      check("t5_err_before", 32'(err_o), 32'd0);
      grant_i = 32'h0000_0014; beat_len_i = 8'd0;
      step();
      check("t5_idx2", 32'(out_idx_o), 32'd2);
      check("t5_err",  32'(err_o),     32'(exp_err));
      grant_i = '0;
      step();
      check("t5_release", release_o, 32'h0000_0004);
      step(); step();
      check("t5_err_sticky", 32'(err_o), 32'(exp_err));

      // Reset mid-transaction after 1 of 4 beats.
      grant_i = 32'h0000_0080; beat_len_i = 8'd4;
      step();
      grant_i = '0;
      step();
      beat_i = 1'b1;
      step();
      beat_i = 1'b0; rst_i = 1'b1;
      step();
      check("t6_valid",   32'(out_valid_o), 32'd0);
      check("t6_idx",     32'(out_idx_o),   32'd0);
      check("t6_len",     32'(out_len_o),   32'd0);
      check("t6_busy",    32'(busy_o),      32'd0);
      check("t6_release", release_o,        32'd0);
      check("t6_err",     32'(err_o),       32'd0);
      rst_i = 1'b0;
      step();
      check("t6_norel_after", release_o,   32'd0);
      check("t6_idle_after",  32'(busy_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
